nibbler_out_port: RTL and testbench
===================================

# nibbler_out_port

Parametrised multi-channel output port for the NibblER bus. It replaces the single 4-bit enabled output register with CHANNELS independently addressed output registers. Each channel has a per-channel display mode: direct, blink, timed pulse, or off. The block sits on the data bus at the LED/output boundary and is written by the control unit through one enable/select/data interface.

## Interface
Parameters:
- WIDTH, 4: data width per channel (bits of D and of each Q slice).
- CHANNELS, 2: number of output channels, ≥1.
- BLINK_DIV, 8: blink half-period in clk cycles, ≥1.
- PULSE_LEN, 4: PULSE-mode display length in clk cycles, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  write strobe, sampled at the rising edge.
- wr_mode  in  1  0 = write data register, 1 = write mode register.
- sel  in  max(1,$clog2(CHANNELS))  target channel.
- D  in  WIDTH  write data; in mode writes, D[1:0] is the mode.
- Q  out  CHANNELS*WIDTH  channel c drives Q[c*WIDTH +: WIDTH].
- pulse_active  out  CHANNELS  1 while channel's pulse counter is non-zero.

## Operation
- Per-channel state: data[WIDTH], mode[2], pulse_cnt.
- Shared state: prescaler count and a blink phase bit.
- Mode encoding: DIRECT=0, BLINK=1, PULSE=2, OFF=3.
- Reset:
  - All data = 0, all mode = DIRECT, all pulse_cnt = 0.
  - Prescaler = 0, phase = 1.
  - Q = 0, pulse_active = 0.
- Write rules:
  - enable=1, wr_mode=0, sel<CHANNELS: data[sel] <= D.
  - If mode[sel] is PULSE, the same write also loads pulse_cnt[sel] <= PULSE_LEN.
  - enable=1, wr_mode=1, sel<CHANNELS: mode[sel] <= D[1:0] and pulse_cnt[sel] <= 0. data is retained.
  - sel ≥ CHANNELS: write ignored, no state change.
  - enable=0: no writes. Counters and prescaler still run.
- Output function per channel (from current state):
  - DIRECT: Q = data.
  - BLINK: Q = phase ? data : 0.
  - PULSE: Q = (pulse_cnt≠0) ? data : 0.
  - OFF: Q = 0.
- Pulse counter:
  - Decrements by 1 each cycle while non-zero.
  - A write during an active pulse reloads PULSE_LEN, restarting the pulse.
- Prescaler:
  - Counts 0..BLINK_DIV-1 and wraps.
  - On wrap, phase toggles.
  - Free-running, shared by all channels.
  - Mode changes do not reset it.
- Width rules:
  - pulse_cnt is $clog2(PULSE_LEN+1) bits.
  - Prescaler is max(1,$clog2(BLINK_DIV)) bits.
  - No overflow is possible.

## Timing
- Q and pulse_active are registered, with no combinational path from inputs.
- A write sampled at edge k is visible on Q from cycle k+1 (1-cycle latency).
- PULSE: Q = data for exactly PULSE_LEN cycles, starting at cycle k+1; 0 afterwards.
- BLINK: starting from reset, Q = data for BLINK_DIV cycles, then 0 for BLINK_DIV cycles, repeating.
- Entering BLINK mid-stream follows the current shared phase, with no re-alignment.
- Reset asserted mid-pulse or mid-blink: all state returns to reset values at that edge. reset has priority over enable.
- One write per cycle by construction; no simultaneous-write arbitration is needed.

## Structure
- Package nibbler_out_pkg holds:
  - the mode localparams (MODE_DIRECT, MODE_BLINK, MODE_PULSE, MODE_OFF);
  - the 2-bit mode typedef.
- Sub-module nibbler_out_chan holds one channel's data, mode, pulse_cnt and output mux.
  - Inputs: write-data strobe, write-mode strobe, D, phase.
  - Instantiated CHANNELS times in a generate loop.
- The top level holds the sel decode, the prescaler/phase logic and the Q concatenation.

## Test plan
Bench parameters: WIDTH=4, CHANNELS=2, BLINK_DIV=4, PULSE_LEN=3.
- Reset, then data write ch1 D=0xA → Q = 0xA0 from next cycle; ch0 stays 0.
- Mode write ch0 = BLINK, then data write ch0 = 0x5 → ch0 alternates 0x5 and 0x0 every 4 cycles, aligned to the shared phase.
- Mode write ch1 = PULSE, then data write 0xC → ch1 = 0xC for exactly 3 cycles, pulse_active[1]=1 for those 3 cycles, then 0.
- Rewrite 0x3 on the 2nd pulse cycle → pulse restarts; ch1 = 0x3 for 3 more cycles.
- Mode write ch1 = OFF → ch1 = 0; mode write DIRECT → ch1 = the retained 0x3.
- Write with sel=1 when CHANNELS=1 → ignored.
- Reset asserted mid-pulse with enable=1 → Q=0, pulse_active=0 and mode DIRECT on the next cycle.

Source files
------------

// File: rtl/nibbler_out_pkg.sv
// rtl/nibbler_out_pkg.sv - shared mode encodings for the NibblER output port
//
// Purpose : 2-bit display-mode type and its four encodings, used by the
//           channel sub-module and by anything decoding mode writes.
// Ports   : none (package).
package nibbler_out_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIRECT = 2'd0;
    localparam mode_t MODE_BLINK  = 2'd1;
    localparam mode_t MODE_PULSE  = 2'd2;
    localparam mode_t MODE_OFF    = 2'd3;

endpackage

// File: rtl/nibbler_out_chan.sv
// rtl/nibbler_out_chan.sv - one output channel: data, mode, pulse counter, output mux
//
// Purpose : holds a single channel's data register, display mode and pulse
//           counter, and selects what the channel shows on its output slice.
// Ports   : clk, reset       - clock, synchronous active-high reset
//           wr_data_i        - write strobe for the data register
//           wr_mode_i        - write strobe for the mode register (D[1:0])
//           d_i              - write data
//           phase_i          - shared blink phase from the top level
//           q_o              - channel output slice
//           pulse_active_o   - high while the pulse counter is non-zero
module nibbler_out_chan
    import nibbler_out_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_data_i,
    input  logic             wr_mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             phase_i,
    output logic [WIDTH-1:0] q_o,
    output logic             pulse_active_o
);

    localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] data_q, data_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            mode_q <= MODE_DIRECT;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        cnt_d  = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
        if (wr_data_i) begin
            data_d = d_i;
            // A data write in PULSE mode (re)starts the pulse, even mid-pulse.
            if (mode_q == MODE_PULSE) begin
                cnt_d = CNT_LOAD;
            end
        end else if (wr_mode_i) begin
            // Changing mode cancels any running pulse; data is kept.
            mode_d = mode_t'(d_i[1:0]);
            cnt_d  = '0;
        end
    end

    // Output is a function of registered state only, so there is no
    // combinational path from the write inputs to q_o.
    always_comb begin
        q_o = '0;
        case (mode_q)
            MODE_DIRECT: q_o = data_q;
            MODE_BLINK:  q_o = phase_i ? data_q : '0;
            MODE_PULSE:  q_o = (cnt_q != '0) ? data_q : '0;
            default:     q_o = '0;
        endcase
    end

    assign pulse_active_o = (cnt_q != '0);

endmodule

// File: rtl/nibbler_out_port.sv
// rtl/nibbler_out_port.sv - multi-channel NibblER output port with per-channel display modes
//
// Purpose : decodes enable/wr_mode/sel writes onto CHANNELS output channels,
//           runs the shared blink prescaler and concatenates channel outputs.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           enable         - write strobe
//           wr_mode        - 0 writes data register, 1 writes mode register
//           sel            - target channel; values >= CHANNELS are ignored
//           D              - write data (D[1:0] is the mode on mode writes)
//           Q              - channel c on Q[c*WIDTH +: WIDTH]
//           pulse_active   - per-channel pulse counter non-zero
module nibbler_out_port
    import nibbler_out_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int BLINK_DIV = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic                                       wr_mode,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
    input  logic [WIDTH-1:0]                           D,
    output logic [CHANNELS*WIDTH-1:0]                  Q,
    output logic [CHANNELS-1:0]                        pulse_active
);

    localparam int               SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int               PRE_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BLINK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             phase_q, phase_d;
    logic             wrap;

    // Free-running shared blink timebase; phase starts high so every
    // BLINK channel shows data for the first BLINK_DIV cycles after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            phase_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        wrap    = (presc_q == PRE_MAX);
        presc_d = wrap ? '0 : presc_q + PRE_ONE;
        phase_d = wrap ? ~phase_q : phase_q;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        // Only sel values that name an existing channel can match, so
        // out-of-range selects fall through with no write.
        logic hit;
        assign hit = enable && (sel == SEL_W'(c));

        nibbler_out_chan #(
            .WIDTH     (WIDTH),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .wr_data_i      (hit && !wr_mode),
            .wr_mode_i      (hit && wr_mode),
            .d_i            (D),
            .phase_i        (phase_q),
            .q_o            (Q[c*WIDTH +: WIDTH]),
            .pulse_active_o (pulse_active[c])
        );
    end

endmodule

// File: tb/tb_nibbler_out_port.sv
// tb/tb_nibbler_out_port.sv - scoreboard bench for nibbler_out_port
module tb_nibbler_out_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       wr_mode = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] D = 4'h0;
    logic [7:0] Q;
    logic [1:0] pulse_active;
    logic [3:0] Q1;
    logic       pulse_active1;

    always #5 clk = ~clk;

    nibbler_out_port #(
        .WIDTH(4), .CHANNELS(2), .BLINK_DIV(4), .PULSE_LEN(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_mode(wr_mode),
        .sel(sel), .D(D), .Q(Q), .pulse_active(pulse_active)
    );

    // Single-channel copy sharing every input: it must track channel 0 of
    // the main instance and ignore all sel=1 writes.
    nibbler_out_port #(
        .WIDTH(4), .CHANNELS(1), .BLINK_DIV(4), .PULSE_LEN(3)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .wr_mode(wr_mode),
        .sel(sel), .D(D), .Q(Q1), .pulse_active(pulse_active1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       wm;
        logic       s;
        logic [3:0] d;
        logic [7:0] q;
        logic [1:0] pa;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] q;
        logic [1:0] pa;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic en, input logic wm,
                       input logic s, input logic [3:0] d,
                       input logic [7:0] q, input logic [1:0] pa);
        vec_t v;
        v.rst = rst; v.en = en; v.wm = wm; v.s = s; v.d = d; v.q = q; v.pa = pa;
        vecs.push_back(v);
    endtask

    // Idle cycle: enable low with junk on D/sel.
    task automatic idle(input logic [7:0] q, input logic [1:0] pa);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, q, pa);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%h, expected 0x%h", name, idx, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("Q",             e.idx, Q,                     e.q);
            chk("pulse_active",  e.idx, {6'd0, pulse_active},  {6'd0, e.pa});
            chk("Q_1ch",         e.idx, {4'd0, Q1},            {4'd0, e.q[3:0]});
            chk("pulse_1ch",     e.idx, {7'd0, pulse_active1}, {7'd0, e.pa[0]});
        end
    end

    initial begin
        // Expected values are state after the edge that samples the vector.
        // Blink: phase high for cycles 0-3 after reset, low 4-7, high 8-11...
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 2'b00); // reset, n=0
        idle(8'h00, 2'b00);                              // n=1
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 8'hA0, 2'b00); // ch1 data A, n=2
        idle(8'hA0, 2'b00);                              // n=3
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 8'hA0, 2'b00); // ch0 BLINK, n=4
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 8'hA0, 2'b00); // ch0 data 5, n=5 phase 0
        idle(8'hA0, 2'b00);                              // n=6
        idle(8'hA0, 2'b00);                              // n=7
        idle(8'hA5, 2'b00);                              // n=8 phase 1
        idle(8'hA5, 2'b00);                              // n=9
        idle(8'hA5, 2'b00);                              // n=10
        idle(8'hA5, 2'b00);                              // n=11
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 8'h00, 2'b00); // ch1 PULSE, n=12 phase 0
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 8'hC0, 2'b10); // ch1 data C, cnt=3
        idle(8'hC0, 2'b10);                              // cnt=2
        idle(8'hC0, 2'b10);                              // cnt=1
        idle(8'h05, 2'b00);                              // n=16 phase 1, pulse over
        idle(8'h05, 2'b00);                              // n=17
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 8'hC5, 2'b10); // new pulse, cnt=3
        idle(8'hC5, 2'b10);                              // cnt=2
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'h30, 2'b10); // restart, n=20 phase 0
        idle(8'h30, 2'b10);                              // cnt=2
        idle(8'h30, 2'b10);                              // cnt=1
        idle(8'h00, 2'b00);                              // n=23
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 8'h05, 2'b00); // ch1 OFF, n=24 phase 1
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 8'h35, 2'b00); // ch1 DIRECT, data kept
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 8'h05, 2'b00); // ch1 PULSE again
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 8'h95, 2'b10); // ch1 pulse 9, cnt=3
        add(1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 8'h00, 2'b00); // reset wins over write
        idle(8'h00, 2'b00);                              // n=1
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 8'h60, 2'b00); // ch1 DIRECT: no pulse
        idle(8'h60, 2'b00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'h6F, 2'b00); // ch0 DIRECT, n=4 (phase 0)

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            reset   = vecs[i].rst;
            enable  = vecs[i].en;
            wr_mode = vecs[i].wm;
            sel     = vecs[i].s;
            D       = vecs[i].d;
            @(posedge clk);
            #1;
            e.idx = i;
            e.q   = vecs[i].q;
            e.pa  = vecs[i].pa;
            exp_q.push_back(e);
        end

        @(negedge clk);
        enable = 1'b0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
